execute_stage: RTL and testbench
================================

EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 SHALL have port clock, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port reset_n, input, 1, synchronous active-low reset sampled on rising clock.
REQ-003 SHALL have port enable_execute, input, 1, capture strobe; outputs update only when high.
REQ-004 SHALL have port ir, input, 16, instruction from decode stage.
REQ-005 SHALL have port npc_in, input, 16, next-PC from decode stage.
REQ-006 SHALL have port E_control, input, 6, as follows:
  - [5:4] alu_control: 0 ADD, 1 AND, 2 NOT, 3 reserved, treated as ADD.
  - [3:2] pcselect1: 0 sext IR[10:0], 1 sext IR[8:0], 2 sext IR[5:0], 3 zero.
  - [1] pcselect2: 1 npc_in, 0 VSR1.
  - [0] op2select: 1 VSR2, 0 sext IR[4:0].
REQ-007 SHALL have port W_control, input, 2, writeback select passed through.
REQ-008 SHALL have port mem_control, input, 1, indirect-access flag passed through.
REQ-009 SHALL have port VSR1, input, 16, register-file value for sr1.
REQ-010 SHALL have port VSR2, input, 16, register-file value for sr2.
REQ-011 SHALL have port sr1, output, 3, combinational: IR[8:6].
REQ-012 SHALL have port sr2, output, 3, combinational: IR[11:9] for ST/STR/STI (opcodes 0011/0111/1011), else IR[2:0].
REQ-013 SHALL have registered output aluout, 16: ALU result or effective address.
REQ-014 SHALL have registered output pcout, 16: effective address.
REQ-015 SHALL have registered output dr, 3: destination register.
REQ-016 SHALL have registered output M_data, 16: store data.
REQ-017 SHALL have registered output NZP, 3: branch condition mask.
REQ-018 SHALL have registered outputs IR_Exec (16), W_control_out (2), mem_control_out (1): pipelined copies of the inputs.

Function
REQ-019 SHALL compute addr = (pcselect2 ? npc_in : VSR1) + offset(pcselect1), modulo 2^16, carry discarded.
REQ-020 SHALL compute ALU result with op2 = op2select ? VSR2 : sext(IR[4:0]), as follows:
  - ADD: VSR1+op2, mod 2^16.
  - AND: VSR1&op2.
  - NOT: ~VSR1.
REQ-021 On rising clock with reset_n=1 and enable_execute=1, the registered outputs SHALL load as follows:
  - aluout: ALU result for opcodes 0001/0101/1001; addr for all other opcodes.
  - pcout: addr.
  - dr: IR[11:9] for ADD/AND/NOT/LD/LDR/LDI/LEA; 0 otherwise.
  - M_data: VSR2 for ST/STR/STI; 0 otherwise.
  - NZP: IR[11:9] for BR (0000); 3'b111 for JMP (1100); 3'b000 otherwise.
  - IR_Exec: ir. W_control_out: W_control. mem_control_out: mem_control.
REQ-022 Latency SHALL be exactly one clock from capture edge to registered output valid.
REQ-023 When enable_execute=0, all registered outputs SHALL hold their values regardless of input changes; sr1/sr2 still track ir.
REQ-024 Undefined opcodes (1101, 1000, 1111, 0100) SHALL be treated as non-ALU, non-store: aluout=addr, dr=0, NZP=0, M_data=0.

Reset
REQ-025 On rising clock with reset_n=0, all registered outputs SHALL become 0, overriding enable_execute.
REQ-026 Reset asserted mid-stream SHALL discard the in-flight capture; the first valid output follows the first enabled edge after release.

Verification
REQ-027 Reset: reset_n=0 for one edge with enable_execute=1 and random inputs -> all registered outputs 0.
REQ-028 Register ADD: ir=16'h1642, E_control=6'b000001, VSR1=5, VSR2=7 -> next edge aluout=16'h000C, dr=3, NZP=0; sr1=1, sr2=2.
REQ-029 Immediate wrap: ir=16'h147F, E_control=6'b000000, VSR1=0 -> aluout=16'hFFFF, dr=2.
REQ-030 Branch: ir=16'h0DFE, E_control=6'b000110, npc_in=16'h3005 -> pcout=aluout=16'h3003, NZP=3'b110, dr=0.
REQ-031 Store plus hold: STR with VSR2=16'hBEEF -> M_data=16'hBEEF, sr2=IR[11:9]; then enable_execute=0 for 3 cycles with new inputs -> all registered outputs unchanged.
REQ-032 Reset mid-op: enabled ADD capture on the same edge as reset_n=0 -> outputs 0; after release, the next enabled instruction appears after one edge.

Source files
------------

// File: rtl/execute_stage.sv
// Execute stage: ALU and effective-address generation for a 16-bit LC-3 style pipeline.
// Everything registered loads together on an enabled clock edge; sr1/sr2 are combinational.
module execute_stage (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        enable_execute,
   input  logic [15:0] ir,
   input  logic [15:0] npc_in,
   input  logic [5:0]  E_control,
   input  logic [1:0]  W_control,
   input  logic        mem_control,
   input  logic [15:0] VSR1,
   input  logic [15:0] VSR2,
   output logic [2:0]  sr1,
   output logic [2:0]  sr2,
   output logic [15:0] aluout,
   output logic [15:0] pcout,
   output logic [2:0]  dr,
   output logic [15:0] M_data,
   output logic [2:0]  NZP,
   output logic [15:0] IR_Exec,
   output logic [1:0]  W_control_out,
   output logic        mem_control_out
);

   logic [3:0]  opcode;
   logic [1:0]  alu_control, pcselect1;
   logic        pcselect2, op2select;
   logic [15:0] offset, base, addr, op2, alu_res;
   logic        is_alu, is_load, is_store;

   assign opcode      = ir[15:12];
   assign alu_control = E_control[5:4];
   assign pcselect1   = E_control[3:2];
   assign pcselect2   = E_control[1];
   assign op2select   = E_control[0];

   // ADD/AND/NOT share the 01 low opcode bits; stores share 11.
   assign is_alu   = (opcode == 4'b0001) || (opcode == 4'b0101) || (opcode == 4'b1001);
   assign is_load  = (opcode == 4'b0010) || (opcode == 4'b0110) || (opcode == 4'b1010)
                  || (opcode == 4'b1110);
   assign is_store = (opcode == 4'b0011) || (opcode == 4'b0111) || (opcode == 4'b1011);

   assign sr1 = ir[8:6];
   assign sr2 = is_store ? ir[11:9] : ir[2:0];

   always_comb begin
      offset = '0;
      case (pcselect1)
         2'd0:    offset = {{5{ir[10]}}, ir[10:0]};
         2'd1:    offset = {{7{ir[8]}}, ir[8:0]};
         2'd2:    offset = {{10{ir[5]}}, ir[5:0]};
         default: offset = '0;
      endcase
   end

   assign base = pcselect2 ? npc_in : VSR1;
   assign addr = base + offset;
   assign op2  = op2select ? VSR2 : {{11{ir[4]}}, ir[4:0]};

   always_comb begin
      alu_res = VSR1 + op2;
      case (alu_control)
         2'd1:    alu_res = VSR1 & op2;
         2'd2:    alu_res = ~VSR1;
         default: alu_res = VSR1 + op2;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         aluout          <= '0;
         pcout           <= '0;
         dr              <= '0;
         M_data          <= '0;
         NZP             <= '0;
         IR_Exec         <= '0;
         W_control_out   <= '0;
         mem_control_out <= 1'b0;
      end else if (enable_execute) begin
         aluout          <= is_alu ? alu_res : addr;
         pcout           <= addr;
         dr              <= (is_alu || is_load) ? ir[11:9] : 3'd0;
         M_data          <= is_store ? VSR2 : 16'd0;
         if (opcode == 4'b0000)
            NZP <= ir[11:9];
         else if (opcode == 4'b1100)
            NZP <= 3'b111;
         else
            NZP <= 3'b000;
         IR_Exec         <= ir;
         W_control_out   <= W_control;
         mem_control_out <= mem_control;
      end
   end

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: a behavioural model predicts each edge's result,
// pushes it to a queue, and the entry is popped and compared one cycle later.
module tb_execute_stage;

   logic        clock = 1'b0;
   logic        reset_n, enable_execute, mem_control;
   logic [15:0] ir, npc_in, VSR1, VSR2;
   logic [5:0]  E_control;
   logic [1:0]  W_control;
   logic [2:0]  sr1, sr2, dr, NZP;
   logic [15:0] aluout, pcout, M_data, IR_Exec;
   logic [1:0]  W_control_out;
   logic        mem_control_out;

   typedef struct packed {
      logic [15:0] alu, pc, md, irx;
      logic [2:0]  dr, nzp;
      logic [1:0]  w;
      logic        m;
   } exp_t;

   exp_t   cur_exp;
   exp_t   sb[$];
   int     n_chk  = 0;
   int     n_fail = 0;

   execute_stage dut (
      .clock(clock), .reset_n(reset_n), .enable_execute(enable_execute),
      .ir(ir), .npc_in(npc_in), .E_control(E_control), .W_control(W_control),
      .mem_control(mem_control), .VSR1(VSR1), .VSR2(VSR2),
      .sr1(sr1), .sr2(sr2), .aluout(aluout), .pcout(pcout), .dr(dr),
      .M_data(M_data), .NZP(NZP), .IR_Exec(IR_Exec),
      .W_control_out(W_control_out), .mem_control_out(mem_control_out)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input exp_t prev);
      exp_t        e;
      logic [15:0] off, addr, op2, res;
      if (!reset_n) return '0;
      if (!enable_execute) return prev;
      case (E_control[3:2])
         2'd0: off = {{5{ir[10]}}, ir[10:0]};
         2'd1: off = {{7{ir[8]}}, ir[8:0]};
         2'd2: off = {{10{ir[5]}}, ir[5:0]};
         default: off = 16'd0;
      endcase
      addr = (E_control[1] ? npc_in : VSR1) + off;
      op2  = E_control[0] ? VSR2 : {{11{ir[4]}}, ir[4:0]};
      if (E_control[5:4] == 2'd1)      res = VSR1 & op2;
      else if (E_control[5:4] == 2'd2) res = ~VSR1;
      else                             res = VSR1 + op2;
      e = '0;
      e.alu = addr;
      e.pc  = addr;
      e.irx = ir;
      e.w   = W_control;
      e.m   = mem_control;
      case (ir[15:12])
         4'h1, 4'h5, 4'h9:        begin e.alu = res; e.dr = ir[11:9]; end
         4'h2, 4'h6, 4'hA, 4'hE:  e.dr = ir[11:9];
         4'h3, 4'h7, 4'hB:        e.md = VSR2;
         4'h0:                    e.nzp = ir[11:9];
         4'hC:                    e.nzp = 3'b111;
         default: ;
      endcase
      return e;
   endfunction

   // Check sources, predict, clock once, then compare the popped prediction.
   task automatic step(input string tag);
      exp_t e;
      logic [2:0] esr2;
      #1;
      case (ir[15:12])
         4'h3, 4'h7, 4'hB: esr2 = ir[11:9];
         default:          esr2 = ir[2:0];
      endcase
      chk({tag, ".sr1"}, {13'd0, sr1}, {13'd0, ir[8:6]});
      chk({tag, ".sr2"}, {13'd0, sr2}, {13'd0, esr2});
      cur_exp = model(cur_exp);
      sb.push_back(cur_exp);
      @(posedge clock);
      #1;
      if (sb.size() == 0) begin
         chk({tag, ".sb_empty"}, 16'd1, 16'd0);
      end else begin
         e = sb.pop_front();
         chk({tag, ".aluout"}, aluout, e.alu);
         chk({tag, ".pcout"},  pcout,  e.pc);
         chk({tag, ".M_data"}, M_data, e.md);
         chk({tag, ".IR_Exec"}, IR_Exec, e.irx);
         chk({tag, ".dr"},  {13'd0, dr},  {13'd0, e.dr});
         chk({tag, ".NZP"}, {13'd0, NZP}, {13'd0, e.nzp});
         chk({tag, ".W_out"}, {14'd0, W_control_out}, {14'd0, e.w});
         chk({tag, ".m_out"}, {15'd0, mem_control_out}, {15'd0, e.m});
      end
   endtask

   task automatic rand_inputs();
      ir          = 16'($urandom);
      npc_in      = 16'($urandom);
      E_control   = 6'($urandom);
      W_control   = 2'($urandom);
      mem_control = 1'($urandom);
      VSR1        = 16'($urandom);
      VSR2        = 16'($urandom);
   endtask

   initial begin
      cur_exp = '0;
      // Reset with enable high and random inputs
      rand_inputs();
      reset_n = 1'b0; enable_execute = 1'b1;
      step("reset");

      // Register ADD
      reset_n = 1'b1;
      ir = 16'h1642; E_control = 6'b000001; VSR1 = 16'd5; VSR2 = 16'd7;
      npc_in = 16'h3000; W_control = 2'd1; mem_control = 1'b0;
      step("add_reg");
      chk("add_reg.lit_alu", aluout, 16'h000C);
      chk("add_reg.lit_dr", {13'd0, dr}, 16'd3);

      // Immediate add wrapping to FFFF
      ir = 16'h147F; E_control = 6'b000000; VSR1 = 16'd0;
      step("add_imm");
      chk("add_imm.lit_alu", aluout, 16'hFFFF);

      // Branch with negative 9-bit offset from npc
      ir = 16'h0DFE; E_control = 6'b000110; npc_in = 16'h3005;
      step("br");
      chk("br.lit_pc", pcout, 16'h3003);
      chk("br.lit_nzp", {13'd0, NZP}, 16'h0006);

      // JMP, AND, NOT, LEA, undefined opcode
      ir = 16'hC1C0; E_control = 6'b001100; VSR1 = 16'h4000; step("jmp");
      ir = 16'h5A43; E_control = 6'b010001; VSR1 = 16'hF0F0; VSR2 = 16'h0FF0; step("and");
      ir = 16'h967F; E_control = 6'b100000; VSR1 = 16'h1234; step("not");
      chk("not.lit_alu", aluout, 16'hEDCB);
      ir = 16'hE7FF; E_control = 6'b000110; npc_in = 16'h0010; step("lea");
      ir = 16'hDFFF; E_control = 6'b000001; VSR1 = 16'h0100; VSR2 = 16'h0200; step("undef");

      // STR then three held cycles with changing inputs
      ir = 16'h7A83; E_control = 6'b001000; VSR1 = 16'h2000; VSR2 = 16'hBEEF;
      step("str");
      chk("str.lit_md", M_data, 16'hBEEF);
      enable_execute = 1'b0;
      for (int i = 0; i < 3; i++) begin
         rand_inputs();
         step("hold");
      end
      chk("hold.lit_md", M_data, 16'hBEEF);

      // Reset on the same edge as an enabled ADD, then resume
      enable_execute = 1'b1; reset_n = 1'b0;
      ir = 16'h1642; E_control = 6'b000001; VSR1 = 16'd9; VSR2 = 16'd1;
      step("rst_mid");
      reset_n = 1'b1;
      ir = 16'h1A81; E_control = 6'b000001; VSR1 = 16'd100; VSR2 = 16'd23;
      step("post_rst");
      chk("post_rst.lit_alu", aluout, 16'd123);

      // Random mix of enables and occasional resets
      for (int i = 0; i < 60; i++) begin
         rand_inputs();
         enable_execute = ($urandom_range(3) != 0);
         reset_n        = ($urandom_range(15) != 0);
         step("rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
